// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate-extension unit placed between decode and the ID/EX
// register. It widens an IN_W-bit immediate to OUT_W bits in one of four modes
// (sign, zero, upper, branch = sign-extend then shift left 2). Each result
// carries an opaque tag. A one-entry skid buffer absorbs downstream
// back-pressure, so in_ready never depends combinationally on out_ready.
//
// Ports:
//   Clk        - clock, rising edge
//   Reset      - synchronous, active-high reset
//   in_valid   - upstream offers in_imm / in_mode / in_tag
//   in_ready   - unit can accept this cycle (registered)
//   in_imm     - IN_W-bit immediate
//   in_mode    - 00 sign, 01 zero, 10 upper, 11 branch
//   in_tag     - TAG_W-bit tag returned with the result
//   out_valid  - out_data / out_tag / out_mode hold a valid result
//   out_ready  - downstream accepts this cycle
//   out_data   - OUT_W-bit extended value
//   out_tag    - tag of the result in out_data
//   out_mode   - mode used for the result in out_data
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_mode
);

  localparam int unsigned P = OUT_W - IN_W;

  // Extension arithmetic for all four modes.
  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [1:0]      mode);
    logic [OUT_W-1:0] sext_v;
    sext_v = {{P{imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend_imm = sext_v;
      2'b01:   extend_imm = {{P{1'b0}}, imm};
      2'b10:   extend_imm = {imm, {P{1'b0}}};
      // OUT_W >= IN_W+2 guarantees the two bits dropped here are sign copies.
      2'b11:   extend_imm = {sext_v[OUT_W-3:0], 2'b00};
      default: extend_imm = sext_v;
    endcase
  endfunction

  // Main (output) register.
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic [1:0]       r_out_mode;
  // Skid register.
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;
  logic [1:0]       r_skid_mode;
  // in_ready kept as its own flop, equal to !skid_valid.
  logic             r_in_ready;

  logic             w_accept;
  logic             w_drain;
  logic             w_main_load;
  logic [OUT_W-1:0] w_in_ext;

  logic             w_out_valid_nxt;
  logic [OUT_W-1:0] w_out_data_nxt;
  logic [TAG_W-1:0] w_out_tag_nxt;
  logic [1:0]       w_out_mode_nxt;
  logic             w_skid_valid_nxt;
  logic [OUT_W-1:0] w_skid_data_nxt;
  logic [TAG_W-1:0] w_skid_tag_nxt;
  logic [1:0]       w_skid_mode_nxt;

  assign w_accept    = in_valid & r_in_ready;
  assign w_drain     = r_out_valid & out_ready;
  assign w_main_load = ~r_out_valid | w_drain;
  assign w_in_ext    = extend_imm(in_imm, in_mode);

  // Next-state of main and skid registers from the handshake.
  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_out_tag_nxt    = r_out_tag;
    w_out_mode_nxt   = r_out_mode;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_tag_nxt   = r_skid_tag;
    w_skid_mode_nxt  = r_skid_mode;

    if (w_main_load) begin
      if (r_skid_valid) begin
        // Older skid entry goes first to keep acceptance order.
        w_out_valid_nxt  = 1'b1;
        w_out_data_nxt   = r_skid_data;
        w_out_tag_nxt    = r_skid_tag;
        w_out_mode_nxt   = r_skid_mode;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_out_valid_nxt  = 1'b1;
        w_out_data_nxt   = w_in_ext;
        w_out_tag_nxt    = in_tag;
        w_out_mode_nxt   = in_mode;
      end else begin
        w_out_valid_nxt  = 1'b0;
      end
    end else begin
      w_out_valid_nxt = r_out_valid;
    end

    // Input accepted but main cannot take it: park it in skid.
    if (w_accept && (!w_main_load || r_skid_valid)) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_data_nxt  = w_in_ext;
      w_skid_tag_nxt   = in_tag;
      w_skid_mode_nxt  = in_mode;
    end else begin
      w_skid_data_nxt  = r_skid_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_tag    <= '0;
      r_out_mode   <= 2'b00;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tag   <= '0;
      r_skid_mode  <= 2'b00;
      r_in_ready   <= 1'b1;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_tag    <= w_out_tag_nxt;
      r_out_mode   <= w_out_mode_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_tag   <= w_skid_tag_nxt;
      r_skid_mode  <= w_skid_mode_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_mode  = r_out_mode;

endmodule
